// File: rtl/lsu_wb_pkg.sv
// Shared definitions for the memory-access / write-back stage.
package lsu_wb_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;

  localparam logic [RegBus-1:0] ZeroWord  = 32'h0000_0000;
  localparam logic              RstEnable = 1'b0;

  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LB   = 4'd1;
  localparam logic [3:0] MEM_OP_LH   = 4'd2;
  localparam logic [3:0] MEM_OP_LW   = 4'd3;
  localparam logic [3:0] MEM_OP_LBU  = 4'd4;
  localparam logic [3:0] MEM_OP_LHU  = 4'd5;
  localparam logic [3:0] MEM_OP_SB   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SW   = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_WB   = 2'd2
  } lsu_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {MEM_OP_LB, MEM_OP_LH, MEM_OP_LW, MEM_OP_LBU, MEM_OP_LHU};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
  endfunction

  function automatic logic is_byte(input logic [3:0] op);
    return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB};
  endfunction

  function automatic logic is_half(input logic [3:0] op);
    return op inside {MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH};
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
    return (is_half(op) && lo[0]) ||
           ((op == MEM_OP_LW || op == MEM_OP_SW) && lo != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication and enables, load lane select and extension.
module lsu_align
  import lsu_wb_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Select enables and replicate store data across the lanes.
  always_comb begin
    sel   = 4'b1111;
    wdata = store_data;
    if (is_byte(op)) begin
      sel   = 4'b0001 << addr_lo;
      wdata = {4{store_data[7:0]}};
    end else if (is_half(op)) begin
      sel   = 4'b0011 << addr_lo;
      wdata = {2{store_data[15:0]}};
    end
  end

  // Pick the addressed lane from read data and extend it to a full word.
  always_comb begin
    byte_v = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MEM_OP_LB:  load_data = {{24{byte_v[7]}}, byte_v};
      MEM_OP_LBU: load_data = {24'h0, byte_v};
      MEM_OP_LH:  load_data = {{16{half_v[15]}}, half_v};
      MEM_OP_LHU: load_data = {16'h0, half_v};
      default:    load_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// Memory-access / write-back stage: ALU pass-through plus req/ack load/store engine.
//
//   state  | meaning
//   IDLE   | accept EX instruction; NONE ops write back next edge
//   WAIT   | bus request outstanding, pipeline stalled, timeout counting
//   WB     | one-cycle register write of captured load data
module lsu_wb
  import lsu_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  input  logic                  ex_we_i,
  input  logic [RegAddrBus-1:0] ex_waddr_i,
  input  logic [RegBus-1:0]     ex_wdata_i,
  input  logic [3:0]            ex_mem_op_i,
  input  logic [31:0]           ex_mem_addr_i,
  input  logic [31:0]           ex_store_data_i,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [3:0]            mem_sel_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  we_o,
  output logic [RegAddrBus-1:0] waddr_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  stall_req_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);

  lsu_state_e state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [RegAddrBus-1:0] rd_q, rd_d;
  logic [1:0]            lo_q, lo_d;
  logic                  flushed_q, flushed_d;
  logic [TO_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]           mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_sel_q, mem_sel_d;
  logic                  we_q, we_d, misalign_q, misalign_d, bus_err_q, bus_err_d;
  logic [RegAddrBus-1:0] waddr_q, waddr_d;
  logic [RegBus-1:0]     wdata_q, wdata_d;
  logic                  stall;

  logic [3:0]  al_op;
  logic [1:0]  al_lo;
  logic [3:0]  al_sel;
  logic [31:0] al_wdata, al_load;

  // Idle steers the incoming instruction; otherwise the latched op drives load extraction.
  assign al_op = (state_q == S_IDLE) ? ex_mem_op_i : op_q;
  assign al_lo = (state_q == S_IDLE) ? ex_mem_addr_i[1:0] : lo_q;

  lsu_align u_align (
    .op         (al_op),
    .addr_lo    (al_lo),
    .store_data (ex_store_data_i),
    .rdata      (mem_rdata_i),
    .sel        (al_sel),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  // Next-state and next-output computation for the whole stage.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    lo_d        = lo_q;
    flushed_d   = flushed_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + 1'b1;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_sel_d   = mem_sel_q;
    mem_wdata_d = mem_wdata_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    stall       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_valid_i && !flush_i) begin
          if (is_load(ex_mem_op_i) || is_store(ex_mem_op_i)) begin
            stall = 1'b1;
            if (is_misaligned(ex_mem_op_i, ex_mem_addr_i[1:0])) begin
              misalign_d = 1'b1;
            end else begin
              op_d        = ex_mem_op_i;
              rd_d        = ex_waddr_i;
              lo_d        = ex_mem_addr_i[1:0];
              flushed_d   = 1'b0;
              cnt_d       = '0;
              mem_req_d   = 1'b1;
              mem_we_d    = is_store(ex_mem_op_i);
              mem_addr_d  = {ex_mem_addr_i[31:2], 2'b00};
              mem_sel_d   = al_sel;
              mem_wdata_d = is_store(ex_mem_op_i) ? al_wdata : ZeroWord;
              state_d     = S_WAIT;
            end
          end else begin
            we_d    = ex_we_i && (ex_waddr_i != '0);
            waddr_d = ex_waddr_i;
            wdata_d = ex_wdata_i;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_inc;
        if (flush_i) flushed_d = 1'b1;
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (is_load(op_q)) begin
            we_d    = (rd_q != '0) && !flushed_q && !flush_i;
            waddr_d = rd_q;
            wdata_d = al_load;
            state_d = S_WB;
          end else begin
            stall   = 1'b0;
            state_d = S_IDLE;
          end
        end else if (TIMEOUT_CYCLES != 0 && cnt_inc == TO_W'(TIMEOUT_CYCLES)) begin
          bus_err_d = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset clears an outstanding request at once.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_q     <= S_IDLE;
      op_q        <= MEM_OP_NONE;
      rd_q        <= '0;
      lo_q        <= '0;
      flushed_q   <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ZeroWord;
      mem_sel_q   <= '0;
      mem_wdata_q <= ZeroWord;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= ZeroWord;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      lo_q        <= lo_d;
      flushed_q   <= flushed_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_sel_q   <= mem_sel_d;
      mem_wdata_q <= mem_wdata_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_sel_o   = mem_sel_q;
  assign mem_wdata_o = mem_wdata_q;
  // A flush arriving in the write-back cycle itself still kills the write.
  assign we_o        = we_q && !(state_q == S_WB && flush_i);
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign stall_req_o = stall;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb with hand-computed expectations.
module tb_lsu_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_we_i = 1'b0;
  logic [4:0]  ex_waddr_i = '0;
  logic [31:0] ex_wdata_i = '0;
  logic [3:0]  ex_mem_op_i = '0;
  logic [31:0] ex_mem_addr_i = '0;
  logic [31:0] ex_store_data_i = '0;
  logic        flush_i = 1'b0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        stall_req_o, misalign_o, bus_err_o;

  int n_checks = 0;
  int n_errors = 0;

  lsu_wb #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid_i      (ex_valid_i),
    .ex_we_i         (ex_we_i),
    .ex_waddr_i      (ex_waddr_i),
    .ex_wdata_i      (ex_wdata_i),
    .ex_mem_op_i     (ex_mem_op_i),
    .ex_mem_addr_i   (ex_mem_addr_i),
    .ex_store_data_i (ex_store_data_i),
    .flush_i         (flush_i),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_sel_o       (mem_sel_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_rdata_i     (mem_rdata_i),
    .mem_ack_i       (mem_ack_i),
    .we_o            (we_o),
    .waddr_o         (waddr_o),
    .wdata_o         (wdata_o),
    .stall_req_o     (stall_req_o),
    .misalign_o      (misalign_o),
    .bus_err_o       (bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] rd,
                       input logic we, input logic [31:0] wd, input logic [31:0] sd);
    ex_valid_i = 1'b1;
    ex_mem_op_i = op;
    ex_mem_addr_i = addr;
    ex_waddr_i = rd;
    ex_we_i = we;
    ex_wdata_i = wd;
    ex_store_data_i = sd;
  endtask

  task automatic idle_ex();
    ex_valid_i = 1'b0;
    ex_mem_op_i = 4'd0;
    ex_we_i = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rdata, input int waits,
                          input logic flush_w, input logic flush_wb, input logic exp_we,
                          input logic [31:0] exp_data, input logic [3:0] exp_sel);
    drive(op, addr, rd, 1'b1, 32'h0, 32'h0);
    #1 check({tag, "_stall_acc"}, stall_req_o, 1);
    tick();
    idle_ex();
    check({tag, "_req"}, mem_req_o, 1);
    check({tag, "_maddr"}, mem_addr_o, {addr[31:2], 2'b00});
    check({tag, "_sel"}, mem_sel_o, exp_sel);
    check({tag, "_mwe"}, mem_we_o, 0);
    for (int i = 1; i < waits; i++) begin
      check({tag, "_we_wait"}, we_o, 0);
      tick();
    end
    flush_i = flush_w;
    mem_ack_i = 1'b1;
    mem_rdata_i = rdata;
    #1 check({tag, "_stall_ack"}, stall_req_o, 1);
    tick();
    mem_ack_i = 1'b0;
    flush_i = flush_wb;
    #1;
    check({tag, "_we"}, we_o, exp_we);
    check({tag, "_req_drop"}, mem_req_o, 0);
    check({tag, "_stall_wb"}, stall_req_o, 0);
    if (exp_we) begin
      check({tag, "_wdata"}, wdata_o, exp_data);
      check({tag, "_waddr"}, waddr_o, rd);
    end
    tick();
    flush_i = 1'b0;
    check({tag, "_we_after"}, we_o, 0);
  endtask

  task automatic run_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [3:0] exp_sel,
                           input logic [31:0] exp_wd);
    drive(op, addr, 5'd0, 1'b0, 32'h0, sd);
    #1 check({tag, "_stall_acc"}, stall_req_o, 1);
    tick();
    idle_ex();
    check({tag, "_req"}, mem_req_o, 1);
    check({tag, "_mwe"}, mem_we_o, 1);
    check({tag, "_maddr"}, mem_addr_o, {addr[31:2], 2'b00});
    check({tag, "_sel"}, mem_sel_o, exp_sel);
    check({tag, "_mwdata"}, mem_wdata_o, exp_wd);
    check({tag, "_we_wait"}, we_o, 0);
    mem_ack_i = 1'b1;
    #1 check({tag, "_stall_ack"}, stall_req_o, 0);
    tick();
    mem_ack_i = 1'b0;
    check({tag, "_req_drop"}, mem_req_o, 0);
    check({tag, "_we"}, we_o, 0);
    check({tag, "_stall_after"}, stall_req_o, 0);
  endtask

  task automatic run_misalign(input string tag, input logic [3:0] op, input logic [31:0] addr);
    drive(op, addr, 5'd9, 1'b1, 32'h0, 32'hDEAD_BEEF);
    #1 check({tag, "_stall"}, stall_req_o, 1);
    tick();
    idle_ex();
    check({tag, "_pulse"}, misalign_o, 1);
    check({tag, "_req"}, mem_req_o, 0);
    check({tag, "_we"}, we_o, 0);
    tick();
    check({tag, "_pulse_end"}, misalign_o, 0);
  endtask

  initial begin
    #2;
    check("rst_req", mem_req_o, 0);
    check("rst_we", we_o, 0);
    check("rst_stall", stall_req_o, 0);
    check("rst_misalign", misalign_o, 0);
    check("rst_buserr", bus_err_o, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_sel", mem_sel_o, 0);
    tick();
    #3 rst = 1'b1;
    tick();

    // ALU pass-through, back-to-back
    for (int i = 0; i < 3; i++) begin
      drive(4'd0, 32'h0, 5'd5, 1'b1, 32'h1234_5678 + i, 32'h0);
      #1 check("pt_stall", stall_req_o, 0);
      tick();
      check("pt_we", we_o, 1);
      check("pt_waddr", waddr_o, 5);
      check("pt_wdata", wdata_o, 32'h1234_5678 + i);
    end
    drive(4'd0, 32'h0, 5'd0, 1'b1, 32'hCAFE_0000, 32'h0);
    tick();
    check("pt_rd0_we", we_o, 0);
    drive(4'd12, 32'h0, 5'd6, 1'b1, 32'h0000_0C0C, 32'h0);
    #1 check("pt_badop_stall", stall_req_o, 0);
    tick();
    check("pt_badop_we", we_o, 1);
    check("pt_badop_wdata", wdata_o, 32'h0000_0C0C);
    idle_ex();
    tick();
    check("pt_idle_we", we_o, 0);

    // Loads: lane selection and extension
    run_load("lb",  4'd1, 32'h0000_1003, 5'd7, 32'h80AA_BBCC, 2, 0, 0, 1, 32'hFFFF_FF80, 4'b1000);
    run_load("lbu", 4'd4, 32'h0000_1003, 5'd7, 32'h80AA_BBCC, 2, 0, 0, 1, 32'h0000_0080, 4'b1000);
    run_load("lb1", 4'd1, 32'h0000_1001, 5'd8, 32'h80AA_BB4C, 1, 0, 0, 1, 32'hFFFF_FFBB, 4'b0010);
    run_load("lh",  4'd2, 32'h0000_1002, 5'd8, 32'h80AA_BBCC, 1, 0, 0, 1, 32'hFFFF_80AA, 4'b1100);
    run_load("lhu", 4'd5, 32'h0000_1000, 5'd8, 32'h80AA_BBCC, 3, 0, 0, 1, 32'h0000_BBCC, 4'b0011);
    run_load("lw",  4'd3, 32'h0000_1004, 5'd9, 32'h80AA_BBCC, 1, 0, 0, 1, 32'h80AA_BBCC, 4'b1111);
    run_load("lw_rd0", 4'd3, 32'h0000_1008, 5'd0, 32'h1111_2222, 1, 0, 0, 0, 32'h0, 4'b1111);
    run_load("lw_flw", 4'd3, 32'h0000_100C, 5'd9, 32'h3333_4444, 2, 1, 0, 0, 32'h0, 4'b1111);
    run_load("lw_flwb", 4'd3, 32'h0000_1010, 5'd9, 32'h5555_6666, 1, 0, 1, 0, 32'h0, 4'b1111);

    // Stores
    run_store("sh", 4'd7, 32'h0000_2002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
    run_store("sb", 4'd6, 32'h0000_2001, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5);
    run_store("sw", 4'd8, 32'h0000_2004, 32'h0102_0304, 4'b1111, 32'h0102_0304);

    // Misalignment
    run_misalign("lw_mis", 4'd3, 32'h0000_3001);
    run_misalign("sh_mis", 4'd7, 32'h0000_3003);
    run_misalign("lhu_mis", 4'd5, 32'h0000_3001);

    // Flush in IDLE ignores the instruction; ack outside WAIT is ignored
    drive(4'd0, 32'h0, 5'd5, 1'b1, 32'h7777_7777, 32'h0);
    flush_i = 1'b1;
    mem_ack_i = 1'b1;
    #1 check("fl_idle_stall", stall_req_o, 0);
    tick();
    flush_i = 1'b0;
    mem_ack_i = 1'b0;
    idle_ex();
    check("fl_idle_we", we_o, 0);
    check("ack_idle_req", mem_req_o, 0);

    // Timeout after 4 WAIT cycles
    drive(4'd3, 32'h0000_4000, 5'd10, 1'b1, 32'h0, 32'h0);
    tick();
    idle_ex();
    for (int i = 0; i < 4; i++) begin
      check("to_wait_req", mem_req_o, 1);
      check("to_wait_err", bus_err_o, 0);
      check("to_wait_stall", stall_req_o, 1);
      tick();
    end
    check("to_err", bus_err_o, 1);
    check("to_req_drop", mem_req_o, 0);
    check("to_stall", stall_req_o, 0);
    check("to_we", we_o, 0);
    drive(4'd0, 32'h0, 5'd3, 1'b1, 32'h0000_00AA, 32'h0);
    tick();
    idle_ex();
    check("to_err_end", bus_err_o, 0);
    check("to_idle_we", we_o, 1);
    check("to_idle_wdata", wdata_o, 32'h0000_00AA);

    // Async reset in WAIT
    drive(4'd3, 32'h0000_5000, 5'd11, 1'b1, 32'h0, 32'h0);
    tick();
    idle_ex();
    check("rw_req", mem_req_o, 1);
    #2 rst = 1'b0;
    #1;
    check("rw_req_drop", mem_req_o, 0);
    check("rw_stall", stall_req_o, 0);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h9999_9999;
    tick();
    mem_ack_i = 1'b0;
    #3 rst = 1'b1;
    tick();
    check("rw_no_wb", we_o, 0);
    drive(4'd0, 32'h0, 5'd12, 1'b1, 32'h0000_0055, 32'h0);
    tick();
    idle_ex();
    check("rw_after_we", we_o, 1);
    check("rw_after_waddr", waddr_o, 12);
    check("rw_after_wdata", wdata_o, 32'h0000_0055);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
- Memory-access/write-back stage between the execute stage and the register file.
- Passes ALU results through to the register-file write port.
- Runs load/store transactions on a req/ack data bus, with byte-lane steering, load sign/zero extension, misalignment detection and a bus timeout.
- Drives the register file's we/waddr/wdata, and stalls the pipeline while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles without mem_ack_i before bus_err_o; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset, RstEnable).
- ex_valid_i  in  1  EX presents an instruction this cycle.
- ex_we_i  in  1  instruction writes a register.
- ex_waddr_i  in  5  destination register.
- ex_wdata_i  in  32  ALU result.
- ex_mem_op_i  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; other codes are treated as NONE.
- ex_mem_addr_i  in  32  effective byte address.
- ex_store_data_i  in  32  store source (rs2).
- flush_i  in  1  squash the current/pending write-back.
- mem_req_o  out  1  bus request, registered.
- mem_we_o  out  1  1 = store.
- mem_addr_o  out  32  word address {addr[31:2],2'b00}.
- mem_sel_o  out  4  byte enables.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_rdata_i  in  32  read data, valid with ack.
- mem_ack_i  in  1  single-cycle completion.
- we_o  out  1  register-file write enable.
- waddr_o  out  5  register-file write address.
- wdata_o  out  32  register-file write data.
- stall_req_o  out  1  freeze upstream stages.
- misalign_o  out  1  one-cycle pulse on a misaligned access.
- bus_err_o  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counter 0.
- Async reset mid-transaction drops mem_req_o immediately, with no write-back.
- FSM states: IDLE, WAIT, WB.
- IDLE, ex_valid_i with NONE:
  - Next edge: we_o = ex_we_i & (ex_waddr_i != 0); waddr_o/wdata_o registered.
  - Latency 1, no stall, back-to-back every cycle.
- IDLE, ex_valid_i with a memory op:
  - stall_req_o = 1 combinationally.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): next edge misalign_o = 1 for one cycle; no bus request, no write; stay IDLE.
  - Otherwise latch op/rd/addr/data, set mem_req_o, go to WAIT.
- WAIT:
  - mem_req_o and its address/sel/wdata are held stable.
  - stall_req_o = 1 throughout.
  - Counter increments each cycle.
- WAIT, mem_ack_i:
  - Drop mem_req_o.
  - Load: capture the extended data and go to WB.
  - Store: go to IDLE, with stall_req_o deasserted in the ack cycle.
- WAIT timeout: counter == TIMEOUT_CYCLES without ack gives bus_err_o pulse, drops req, no write-back, returns to IDLE.
- WB (one cycle):
  - we_o = 1 unless rd == 0 or flushed.
  - stall_req_o = 0; go to IDLE.
  - Load latency = accept + wait + 1 cycles.
- mem_sel_o:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << addr[1:0].
  - Word: 1111.
- mem_wdata_o:
  - Byte: {4{d[7:0]}}.
  - Half: {2{d[15:0]}}.
  - Word: d.
- Load extraction: lane chosen by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- we_o is a one-cycle pulse per instruction and is never asserted while in WAIT.
- flush_i:
  - In IDLE: the incoming instruction is ignored.
  - In WAIT: the bus transaction still completes (no abort), but the write-back is suppressed.
  - Same cycle as WB: we_o is forced 0.
- Simultaneous ack and timeout: ack wins.
- mem_ack_i outside WAIT is ignored.

Decomposition:
- Shared package/defines file: MEM_OP_* codes, RegAddrBus/RegBus widths, ZeroWord, RstEnable.
- One natural sub-module, lsu_align: purely combinational store lane replication/sel generation and load extraction/extension.

Test Plan:
- ALU pass-through: NONE op, rd=5, wdata=0x1234_5678 for 3 consecutive cycles -> we_o=1 each following cycle, no stall; rd=0 -> we_o=0.
- LB at 0x1003 with ack after 2 WAIT cycles, rdata=0x80AA_BBCC -> wdata_o=0xFFFF_FF80 in WB; LBU at the same address -> 0x0000_0080.
- SH at 0x2002, data=0x0000_BEEF -> mem_sel_o=1100, mem_wdata_o=0xBEEF_BEEF, mem_we_o=1, we_o never set.
- LW at 0x3001 -> misalign_o pulse, mem_req_o stays 0, no write.
- LW with no ack and TIMEOUT_CYCLES=4 -> bus_err_o pulses after 4 WAIT cycles, req drops, FSM in IDLE; flush_i in WAIT with ack -> we_o=0.
- Assert rst=0 during WAIT -> mem_req_o and stall_req_o immediately 0; after release the next NONE op writes normally.
